// File: rtl/branch_predict_resolve_pkg.sv
// Shared definitions for the branch predictor/resolver: funct3 branch encodings,
// field widths, counter init value and the init/run state encoding.
package branch_predict_resolve_pkg;

  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned CTR_W    = 2;

  localparam logic [FUNCT3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [FUNCT3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [FUNCT3_W-1:0] F3_BGEU = 3'b111;

  // Weakly not-taken.
  localparam logic [CTR_W-1:0] CTR_INIT = 2'b01;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpr_state_t;

endpackage

// File: rtl/branch_predict_resolve_if.sv
// Fetch lookup and execute resolve signals between the pipeline (master)
// and the branch predictor/resolver (slave).
interface branch_predict_resolve_if #(
  parameter int unsigned N = 32
);
  import branch_predict_resolve_pkg::*;

  logic                ready;
  logic                lk_valid;
  logic [N-1:0]        lk_pc;
  logic                pred_valid;
  logic                pred_taken;
  logic                rs_valid;
  logic [N-1:0]        rs_pc;
  logic [FUNCT3_W-1:0] rs_funct3;
  logic [N-1:0]        rs_aluOut;
  logic                rs_aluEqual;
  logic                rs_pred_taken;
  logic                res_valid;
  logic                res_taken;
  logic                mispredict;
  logic                illegal;

  modport master (
    input  ready, pred_valid, pred_taken, res_valid, res_taken, mispredict, illegal,
    output lk_valid, lk_pc, rs_valid, rs_pc, rs_funct3, rs_aluOut, rs_aluEqual,
           rs_pred_taken
  );

  modport slave (
    output ready, pred_valid, pred_taken, res_valid, res_taken, mispredict, illegal,
    input  lk_valid, lk_pc, rs_valid, rs_pc, rs_funct3, rs_aluOut, rs_aluEqual,
           rs_pred_taken
  );

endinterface

// File: rtl/branch_predict_resolve_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import branch_predict_resolve_pkg::*;
(
  input  logic [CTR_W-1:0] cur,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != '1) nxt = cur + CTR_W'(1);
    end else begin
      if (cur != '0) nxt = cur - CTR_W'(1);
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// BHT of 2-bit counters with registered fetch prediction and execute-stage branch
// resolution; `BRANCH_STATS_EN adds branch/mispredict statistics counters.
module branch_predict_resolve
  import branch_predict_resolve_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned PC_LSB      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  branch_predict_resolve_if.slave   bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]               stat_branches,
  output logic [31:0]               stat_mispredicts
`endif
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BHT_ENTRIES - 1);

  bpr_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             init_we;

  logic [CTR_W-1:0] bht [BHT_ENTRIES];

  logic [IDX_W-1:0] lk_idx, rs_idx;
  logic             lk_act, rs_act, rs_upd;
  logic             rs_taken, rs_illegal;
  logic [CTR_W-1:0] ctr_nxt;
  logic             unused_pc_bits;

  assign lk_idx = bus.lk_pc[PC_LSB +: IDX_W];
  assign rs_idx = bus.rs_pc[PC_LSB +: IDX_W];
  assign unused_pc_bits = ^{bus.lk_pc, bus.rs_pc};

  assign bus.ready = (state_q == ST_RUN);
  assign lk_act    = bus.lk_valid & bus.ready;
  assign rs_act    = bus.rs_valid & bus.ready;
  assign rs_upd    = rs_act & ~rs_illegal;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_RUN;
        else                   idx_d   = idx_q + IDX_W'(1);
      end
      ST_RUN: ;
    endcase
  end

  always_comb begin
    rs_taken   = 1'b0;
    rs_illegal = 1'b0;
    case (bus.rs_funct3)
      F3_BEQ:          rs_taken = bus.rs_aluEqual;
      F3_BNE:          rs_taken = ~bus.rs_aluEqual;
      F3_BLT, F3_BLTU: rs_taken = (bus.rs_aluOut == '1);
      F3_BGE, F3_BGEU: rs_taken = (bus.rs_aluOut == '0);
      default:         rs_illegal = 1'b1;
    endcase
  end

  sat_counter2 u_ctr (
    .cur   (bht[rs_idx]),
    .taken (rs_taken),
    .nxt   (ctr_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      idx_q          <= '0;
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_taken  <= 1'b0;
      bus.mispredict <= 1'b0;
      bus.illegal    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      bus.pred_valid <= lk_act;
      bus.pred_taken <= lk_act & bht[lk_idx][1];
      bus.res_valid  <= rs_act;
      bus.res_taken  <= rs_act & rs_taken;
      bus.illegal    <= rs_act & rs_illegal;
      bus.mispredict <= rs_upd & (rs_taken ^ bus.rs_pred_taken);
    end
  end

  // Table is cleared by the init sweep rather than by rst; the lookup above
  // reads the old value when it hits the entry being updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we)     bht[idx_q]  <= CTR_INIT;
      else if (rs_upd) bht[rs_idx] <= ctr_nxt;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (rs_upd) begin
      stat_branches <= stat_branches + 32'd1;
      if (rs_taken ^ bus.rs_pred_taken) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve (64 entries, word PCs); also
// checks statistics counters when built with BRANCH_STATS_EN.
module tb_branch_predict_resolve;
  import branch_predict_resolve_pkg::*;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned LSB     = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_resolve_if #(.N(32)) bus ();

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_predict_resolve #(.N(32), .BHT_ENTRIES(ENTRIES), .PC_LSB(LSB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [1:0]  model [ENTRIES];
  bit          running = 1'b0;
  logic        pred_q [$];
  logic [2:0]  res_q  [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned midx(input logic [31:0] pc);
    return (pc >> LSB) % ENTRIES;
  endfunction

  // Returns {taken, illegal}.
  function automatic logic [1:0] ref_outcome(input logic [2:0] f3, input logic [31:0] alu,
                                             input logic eq);
    if (f3 == 3'b000) return {eq, 1'b0};
    if (f3 == 3'b001) return {~eq, 1'b0};
    if (f3 == 3'b100 || f3 == 3'b110) return {alu == 32'hFFFF_FFFF, 1'b0};
    if (f3 == 3'b101 || f3 == 3'b111) return {alu == 32'h0, 1'b0};
    return 2'b01;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) model[i] = 2'b01;
  endtask

  task automatic step(input bit lk, input logic [31:0] lpc, input bit rs, input logic [31:0] rpc,
                      input logic [2:0] f3, input logic [31:0] alu, input bit eq, input bit pt);
    logic [1:0] o;
    int unsigned i;
    bus.lk_valid      = lk;
    bus.lk_pc         = lpc;
    bus.rs_valid      = rs;
    bus.rs_pc         = rpc;
    bus.rs_funct3     = f3;
    bus.rs_aluOut     = alu;
    bus.rs_aluEqual   = eq;
    bus.rs_pred_taken = pt;
    if (running) begin
      if (lk) pred_q.push_back(model[midx(lpc)][1]);
      if (rs) begin
        o = ref_outcome(f3, alu, eq);
        res_q.push_back({o[1], ~o[0] & (o[1] != pt), o[0]});
        if (!o[0]) begin
          i = midx(rpc);
          if (o[1] && model[i] != 2'b11) model[i] = model[i] + 2'b01;
          else if (!o[1] && model[i] != 2'b00) model[i] = model[i] - 2'b01;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(1'b1, pc, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] alu,
                         input bit eq, input bit pt);
    step(1'b0, 32'h0, 1'b1, pc, f3, alu, eq, pt);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("init_cycles", n, 64);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, bus.ready, 0);
    check({tag, "_outs"}, {bus.pred_valid, bus.pred_taken, bus.res_valid, bus.res_taken,
                           bus.mispredict, bus.illegal}, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pred_valid) begin
        if (pred_q.size() == 0) check("pred_unexpected", bus.pred_valid, 0);
        else check("pred_taken", bus.pred_taken, pred_q.pop_front());
      end else begin
        check("pred_taken_idle", bus.pred_taken, 0);
      end
      if (bus.res_valid) begin
        if (res_q.size() == 0) begin
          check("res_unexpected", bus.res_valid, 0);
        end else begin
          logic [2:0] e;
          e = res_q.pop_front();
          check("res_taken", bus.res_taken, e[2]);
          check("mispredict", bus.mispredict, e[1]);
          check("illegal", bus.illegal, e[0]);
        end
      end else begin
        check("res_idle", {bus.res_taken, bus.mispredict, bus.illegal}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.lk_valid = 1'b0; bus.lk_pc = '0; bus.rs_valid = 1'b0; bus.rs_pc = '0;
    bus.rs_funct3 = '0; bus.rs_aluOut = '0; bus.rs_aluEqual = 1'b0; bus.rs_pred_taken = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
`ifdef BRANCH_STATS_EN
    check("reset_stats", stat_branches | stat_mispredicts, 0);
`endif
    rst = 1'b0;
    // Requests held during init must be ignored.
    bus.lk_valid = 1'b1; bus.rs_valid = 1'b1; bus.rs_funct3 = F3_BEQ; bus.rs_aluEqual = 1'b1;
    wait_ready();
    idle();
    running = 1'b1;

    lookup(32'h0000_0000);
    lookup(32'h1234_5678);
    lookup(32'hFFFF_FFFC);

    resolve(32'h100, F3_BEQ, 32'h0, 1'b1, 1'b0);
    resolve(32'h100, F3_BEQ, 32'h0, 1'b1, 1'b1);
    lookup(32'h100);

    resolve(32'h2C0, F3_BLTU, 32'hFFFF_FFFF, 1'b0, 1'b0);
    resolve(32'h2C4, F3_BGE, 32'h0000_0001, 1'b0, 1'b1);
    resolve(32'h2C8, 3'b010, 32'h0, 1'b1, 1'b1);
    lookup(32'h2C8);
    resolve(32'h2C8, F3_BEQ, 32'h0, 1'b1, 1'b0);
    lookup(32'h2C8);
    resolve(32'h2CC, 3'b011, 32'hFFFF_FFFF, 1'b0, 1'b0);
    resolve(32'h2D0, F3_BLT, 32'h7FFF_FFFF, 1'b0, 1'b1);
    resolve(32'h2D4, F3_BGEU, 32'h8000_0000, 1'b0, 1'b1);
    resolve(32'h2D8, F3_BNE, 32'h0, 1'b0, 1'b1);

    repeat (5) resolve(32'h40, F3_BEQ, 32'h0, 1'b1, 1'b1);
    resolve(32'h40, F3_BNE, 32'h0, 1'b1, 1'b1);
    lookup(32'h40);
    resolve(32'h40, F3_BNE, 32'h0, 1'b1, 1'b1);
    lookup(32'h40);

    step(1'b1, 32'h80, 1'b1, 32'h80, F3_BEQ, 32'h0, 1'b1, 1'b0);
    lookup(32'h80);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] lpc, rpc, alu;
      int unsigned sel;
      lpc = ($urandom_range(0, 3) << 2) | ($urandom_range(0, 3) << 8);
      rpc = ($urandom % 2 == 0) ? lpc : (($urandom_range(0, 3) << 2) | ($urandom_range(0, 3) << 8));
      sel = $urandom_range(0, 2);
      alu = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      step(1'($urandom), lpc, 1'($urandom), rpc, 3'($urandom), alu, 1'($urandom), 1'($urandom));
    end
    repeat (2) idle();
    check("pred_q_drained", pred_q.size(), 0);
    check("res_q_drained", res_q.size(), 0);

    // Reset in the middle of traffic, then re-initialise.
    running = 1'b0;
    rst = 1'b1;
    bus.lk_valid = 1'b1; bus.rs_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("midreset");
`ifdef BRANCH_STATS_EN
    check("midreset_stats", stat_branches | stat_mispredicts, 0);
`endif
    rst = 1'b0;
    model_reset();
    wait_ready();
    idle();
    running = 1'b1;
    lookup(32'h100);
    lookup(32'h40);

`ifdef BRANCH_STATS_EN
    resolve(32'h500, F3_BEQ,  32'h0,         1'b1, 1'b1);
    resolve(32'h504, F3_BEQ,  32'h0,         1'b0, 1'b0);
    resolve(32'h508, F3_BNE,  32'h0,         1'b0, 1'b0);
    resolve(32'h50C, F3_BLT,  32'hFFFF_FFFF, 1'b0, 1'b1);
    resolve(32'h510, F3_BGE,  32'h0,         1'b0, 1'b0);
    resolve(32'h514, F3_BLTU, 32'h5,         1'b0, 1'b1);
    resolve(32'h518, F3_BGEU, 32'h3,         1'b0, 1'b0);
    resolve(32'h51C, F3_BNE,  32'h0,         1'b1, 1'b0);
    resolve(32'h520, F3_BEQ,  32'h0,         1'b1, 1'b1);
    resolve(32'h524, 3'b011,  32'h0,         1'b0, 1'b1);
    repeat (2) idle();
    check("stat_branches", stat_branches, 9);
    check("stat_mispredicts", stat_mispredicts, 3);
`endif

    repeat (2) idle();
    check("pred_q_final", pred_q.size(), 0);
    check("res_q_final", res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
